// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
//   Groups the instruction-memory request/ack bus, the downstream
//   instruction valid/ready bus, the retire-time redirect and the halt flag
//   of the instruction fetch unit.
//
//   master : the fetch unit (drives imem_req/imem_addr, instr_valid, instr,
//            opcode, pc_out, halted; receives imem_ack/imem_rdata,
//            instr_ready, redirect_valid/redirect_pc)
//   slave  : memory + decoder/execute side (the reverse directions)
//
// Parameter ADDR_W must match the ADDR_W of the connected fetch unit.

`default_nettype none

interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  // instruction memory side
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  // downstream instruction stream
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] pc_out;

  // retire-time branch redirect
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  // status
  logic              halted;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr_valid,
    input  instr_ready,
    output instr,
    output opcode,
    output pc_out,
    input  redirect_valid,
    input  redirect_pc,
    output halted
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  opcode,
    input  pc_out,
    output redirect_valid,
    output redirect_pc,
    input  halted
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Front end producing the instruction / 6-bit opcode stream for the
//   opcode decoder. Owns the program counter, fetches 32-bit words over a
//   req/ack handshake (at most one outstanding request), presents each word
//   downstream over valid/ready, applies the branch redirect sampled on the
//   retire edge, and stops for good on the halt opcode until reset.
//   Fetch and issue never overlap: at best one instruction every 2 cycles.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   bus (master)  instr_fetch_unit_if: imem_req/imem_addr/imem_ack/
//                 imem_rdata, instr_valid/instr_ready/instr/opcode/pc_out,
//                 redirect_valid/redirect_pc, halted
//   retire_count  (FETCH_PERF_CNT_EN only) retired instructions, saturating
//   wait_count    (FETCH_PERF_CNT_EN only) cycles with req=1 and ack=0,
//                 saturating
//
// Build option
//   `define FETCH_PERF_CNT_EN to add the two performance counters.

`default_nettype none

module instr_fetch_unit #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [5:0]        HALT_OPCODE = 6'b111111
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_fetch_unit_if.master    bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           retire_count,
  output logic [31:0]           wait_count
`endif
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              req_q;
  logic              valid_q;
  logic [31:0]       instr_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic              halted_q;

  logic              fetch_done;
  logic              retire;
  logic              is_halt;
  logic [ADDR_W-1:0] redirect_target;
  logic              unused_redirect_lsbs;

  // An ack only counts while a request is actually out; stray acks after
  // reset or in ISSUE/HALTED fall through.
  assign fetch_done = req_q && bus.imem_ack;
  assign retire     = valid_q && bus.instr_ready;
  assign is_halt    = (instr_q[31:26] == HALT_OPCODE);

  // Branch targets are forced word aligned.
  assign redirect_target      = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (fetch_done) begin
            instr_q  <= bus.imem_rdata;
            pc_out_q <= pc;
            req_q    <= 1'b0;
            valid_q  <= 1'b1;
            state    <= ISSUE;
          end else begin
            // Request is raised the cycle after reset release and held,
            // address stable, until the memory acks.
            req_q <= 1'b1;
          end
        end

        ISSUE: begin
          if (retire) begin
            valid_q <= 1'b0;
            if (is_halt) begin
              halted_q <= 1'b1;
              state    <= HALTED;
            end else begin
              if (bus.redirect_valid) begin
                pc <= redirect_target;
              end else begin
                pc <= pc + ADDR_W'(4);
              end
              // Next fetch goes out straight away, no idle cycle.
              req_q <= 1'b1;
              state <= FETCH;
            end
          end
        end

        HALTED: begin
          req_q    <= 1'b0;
          valid_q  <= 1'b0;
          halted_q <= 1'b1;
        end

        default: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          state   <= FETCH;
        end
      endcase
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[31:26];
  assign bus.pc_out      = pc_out_q;
  assign bus.halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_count <= '0;
      wait_count   <= '0;
    end else begin
      // The halt instruction's retire is counted too.
      if (retire && (retire_count != '1)) begin
        retire_count <= retire_count + 32'd1;
      end
      if (req_q && !bus.imem_ack && (wait_count != '1)) begin
        wait_count <= wait_count + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none

module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(32)) bus0 ();
  instr_fetch_unit_if #(.ADDR_W(32)) bus1 ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retire_count0, wait_count0, retire_count1, wait_count1;
`endif

  instr_fetch_unit #(
    .ADDR_W     (32),
    .RESET_PC   (32'h0000_0000),
    .HALT_OPCODE(6'b111111)
  ) dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retire_count(retire_count0),
    .wait_count  (wait_count0)
`endif
  );

  instr_fetch_unit #(
    .ADDR_W     (32),
    .RESET_PC   (32'hFFFF_FFFC),
    .HALT_OPCODE(6'b111111)
  ) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retire_count(retire_count1),
    .wait_count  (wait_count1)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference state: where the next fetch must go and what has retired.
  logic [31:0] exp_pc;
  logic [31:0] exp_retire;
  logic [31:0] exp_wait;

  function automatic logic [25:0] low_bits(input logic [31:0] a);
    return a[25:0] ^ 26'h2A55A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counters0();
`ifdef FETCH_PERF_CNT_EN
    chk("retire_count", retire_count0, exp_retire);
    chk("wait_count", wait_count0, exp_wait);
`endif
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    bus0.imem_ack = 1'b0;
    bus0.imem_rdata = '0;
    bus0.instr_ready = 1'b0;
    bus0.redirect_valid = 1'b0;
    bus0.redirect_pc = '0;
    @(negedge clk);
    @(negedge clk);
    exp_pc = 32'h0;
    exp_retire = 0;
    exp_wait = 0;
    chk("rst_req", bus0.imem_req, 0);
    chk("rst_addr", bus0.imem_addr, 32'h0);
    chk("rst_valid", bus0.instr_valid, 0);
    chk("rst_instr", bus0.instr, 0);
    chk("rst_pc_out", bus0.pc_out, 0);
    chk("rst_halted", bus0.halted, 0);
    chk_counters0();
    // stray ack while req=0 must be ignored
    rst0 = 1'b0;
    bus0.imem_ack = 1'b1;
    bus0.imem_rdata = $urandom;
    @(negedge clk);
    bus0.imem_ack = 1'b0;
  endtask

  // One whole instruction on dut0: 'waits' cycles before ack, 'stall' cycles
  // of instr_ready=0 before retire, with the given redirect at retire.
  task automatic do_instr(input int waits, input int stall, input logic [5:0] op,
                          input logic redir, input logic [31:0] tgt);
    logic [31:0] word;
    word = {op, low_bits(exp_pc)};
    for (int j = 0; j <= waits; j++) begin
      chk("f_req", bus0.imem_req, 1);
      chk("f_addr", bus0.imem_addr, exp_pc);
      chk("f_valid", bus0.instr_valid, 0);
      chk("f_halted", bus0.halted, 0);
      bus0.imem_ack = (j == waits);
      bus0.imem_rdata = (j == waits) ? word : $urandom;
      bus0.instr_ready = 1'($urandom_range(0, 1));
      bus0.redirect_valid = 1'($urandom_range(0, 1));
      bus0.redirect_pc = $urandom;
      @(negedge clk);
    end
    bus0.imem_ack = 1'b0;
    bus0.imem_rdata = $urandom;
    exp_wait += 32'(waits);
    for (int s = 0; s <= stall; s++) begin
      chk("i_valid", bus0.instr_valid, 1);
      chk("i_req", bus0.imem_req, 0);
      chk("i_instr", bus0.instr, word);
      chk("i_opcode", bus0.opcode, op);
      chk("i_pc_out", bus0.pc_out, exp_pc);
      bus0.instr_ready = (s == stall);
      bus0.redirect_valid = (s == stall) ? redir : 1'($urandom_range(0, 1));
      bus0.redirect_pc = (s == stall) ? tgt : $urandom;
      @(negedge clk);
    end
    bus0.instr_ready = 1'b0;
    bus0.redirect_valid = 1'b0;
    exp_retire += 1;
    if (op != 6'b111111) begin
      if (redir) exp_pc = {tgt[31:2], 2'b00};
      else exp_pc = exp_pc + 32'd4;
    end
    chk_counters0();
  endtask

  task automatic hold_halted(input int n);
    for (int k = 0; k < n; k++) begin
      chk("h_halted", bus0.halted, 1);
      chk("h_req", bus0.imem_req, 0);
      chk("h_valid", bus0.instr_valid, 0);
      bus0.imem_ack = 1'($urandom_range(0, 1));
      bus0.imem_rdata = $urandom;
      bus0.instr_ready = 1'($urandom_range(0, 1));
      bus0.redirect_valid = 1'($urandom_range(0, 1));
      bus0.redirect_pc = $urandom;
      @(negedge clk);
    end
    bus0.imem_ack = 1'b0;
    bus0.instr_ready = 1'b0;
    bus0.redirect_valid = 1'b0;
    chk_counters0();
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] w1;

    rst1 = 1'b1;
    bus1.imem_ack = 1'b0;
    bus1.imem_rdata = '0;
    bus1.instr_ready = 1'b0;
    bus1.redirect_valid = 1'b0;
    bus1.redirect_pc = '0;

    // ---- dut0: directed opening sequence ----
    reset0();
    do_instr(3, 0, 6'd0, 1'b0, 32'h0);        // waited fetch at 0, wait_count=3
    do_instr(0, 0, 6'd0, 1'b0, 32'h0);        // pc 4, zero wait
    do_instr(0, 5, 6'd0, 1'b0, 32'h0);        // pc 8, downstream stall
    do_instr(0, 0, 6'd0, 1'b0, 32'h0);        // pc 12
    do_instr(1, 0, 6'd5, 1'b1, 32'h103);      // pc 16, redirect -> 0x100
    chk("redirect_addr", bus0.imem_addr, 32'h100);

    // ---- dut0: randomized instruction stream ----
    for (int n = 0; n < 40; n++) begin
      op = 6'($urandom_range(0, 62));
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), op,
               ($urandom_range(0, 3) == 0), $urandom);
    end
    do_instr(1, 1, 6'b111111, 1'b1, $urandom);  // halt, redirect ignored
    hold_halted(10);

    // ---- dut0: halt at pc 20 then reset ----
    reset0();
    for (int n = 0; n < 5; n++) do_instr(0, 0, 6'd0, 1'b0, 32'h0);
    chk("halt_pc", bus0.imem_addr, 32'd20);
    do_instr(0, 2, 6'b111111, 1'b0, 32'h0);
    hold_halted(6);
    reset0();
    chk("post_halt_req", bus0.imem_req, 1);
    chk("post_halt_addr", bus0.imem_addr, 32'h0);

    // ---- dut1: RESET_PC=FFFFFFFC wrap and mid-transaction reset ----
    chk("d1_rst_req", bus1.imem_req, 0);
    chk("d1_rst_addr", bus1.imem_addr, 32'hFFFF_FFFC);
    rst1 = 1'b0;
    @(negedge clk);
    chk("d1_req", bus1.imem_req, 1);
    chk("d1_addr", bus1.imem_addr, 32'hFFFF_FFFC);
    w1 = {6'd1, 26'h155AA33};
    bus1.imem_ack = 1'b1;
    bus1.imem_rdata = w1;
    @(negedge clk);
    bus1.imem_ack = 1'b0;
    chk("d1_valid", bus1.instr_valid, 1);
    chk("d1_instr", bus1.instr, w1);
    chk("d1_pc_out", bus1.pc_out, 32'hFFFF_FFFC);
    bus1.instr_ready = 1'b1;
    @(negedge clk);
    bus1.instr_ready = 1'b0;
    chk("d1_wrap_req", bus1.imem_req, 1);
    chk("d1_wrap_addr", bus1.imem_addr, 32'h0);
    chk("d1_wrap_valid", bus1.instr_valid, 0);
    rst1 = 1'b1;                              // reset with request outstanding
    @(negedge clk);
    chk("d1_mid_req", bus1.imem_req, 0);
    chk("d1_mid_addr", bus1.imem_addr, 32'hFFFF_FFFC);
    chk("d1_mid_valid", bus1.instr_valid, 0);
    rst1 = 1'b0;
    bus1.imem_ack = 1'b1;                     // stray ack, req=0
    bus1.imem_rdata = $urandom;
    @(negedge clk);
    bus1.imem_ack = 1'b0;
    chk("d1_stray_req", bus1.imem_req, 1);
    chk("d1_stray_valid", bus1.instr_valid, 0);
    @(negedge clk);
    chk("d1_stray_valid2", bus1.instr_valid, 0);
    chk("d1_stray_addr", bus1.imem_addr, 32'hFFFF_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
